soc_boot_ctrl: RTL and testbench

SOC_BOOT_CTRL -- requirements
Module: soc_boot_ctrl

---
 rtl/soc_boot_ctrl.sv | 148 ++++++++++++++
 tb/tb_soc_boot_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_boot_ctrl.sv
// Boot controller: streams load words into NUM_REGIONS memory regions in order,
// then releases the core from reset and supervises it until halt or timeout.
module soc_boot_ctrl #(
  parameter int NUM_REGIONS = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT     = 100,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic [NUM_REGIONS-1:0] mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   core_rst,
  input  logic                   halt,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0]        LAST_REGION = 2'(NUM_REGIONS - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CYC_ONE     = CNT_W'(1);
  localparam logic [ADDR_W:0]   WCNT_ONE    = (ADDR_W + 1)'(1);

  logic [1:0]             state_q,    state_d;
  logic [1:0]             region_q,   region_d;
  logic [ADDR_W:0]        wcnt_q,     wcnt_d;
  logic [CNT_W-1:0]       cycle_q,    cycle_d;
  logic                   timeout_q,  timeout_d;
  logic                   overflow_q, overflow_d;
  logic [NUM_REGIONS-1:0] we_q,       we_d;
  logic [ADDR_W-1:0]      addr_q,     addr_d;
  logic [DATA_W-1:0]      wdata_q,    wdata_d;
  logic [NUM_REGIONS-1:0] region_oh;

  always_comb begin
    region_oh = '0;
    for (int i = 0; i < NUM_REGIONS; i++) region_oh[i] = (region_q == 2'(i));
  end

  always_comb begin
    // NOTE: every next-state value starts from a default so no path infers a latch.
    state_d    = state_q;
    region_d   = region_q;
    wcnt_d     = wcnt_q;
    cycle_d    = cycle_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    we_d       = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          region_d   = '0;
          wcnt_d     = '0;
          cycle_d    = '0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          // The counter's top bit marks a full region: the word is dropped.
          if (wcnt_q[ADDR_W]) begin
            overflow_d = 1'b1;
          end else begin
            we_d    = region_oh;
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = in_data;
            wcnt_d  = wcnt_q + WCNT_ONE;
          end
          if (in_last) begin
            wcnt_d   = '0;
            region_d = region_q + 2'd1;
            if (region_q == LAST_REGION) begin
              state_d = S_RUN;
              cycle_d = '0;
            end
          end
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
        end else if (cycle_q == CYC_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cycle_d = cycle_q + CYC_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      region_q   <= '0;
      wcnt_q     <= '0;
      cycle_q    <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      wcnt_q     <= wcnt_d;
      cycle_q    <= cycle_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign core_rst    = (state_q != S_RUN);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Self-checking bench for soc_boot_ctrl: table-driven load vectors, a timed write
// scoreboard, and hand-written halt/timeout/reset sequences.
module tb_soc_boot_ctrl;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int TO = 100;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last, halt;
  logic [DW-1:0] in_data;
  logic          in_ready, core_rst, busy, done, timeout, overflow;
  logic [NR-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] cycle_count;

  soc_boot_ctrl #(
    .NUM_REGIONS(NR), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .halt(halt), .busy(busy),
    .done(done), .timeout(timeout), .overflow(overflow), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [NR-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   due;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic          valid;
    logic          last;
    logic [DW-1:0] data;
    logic          exp_wr;
    logic [NR-1:0] exp_we;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vt[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writes must land exactly one cycle after the accept; any other write is stray.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("mem_we", mem_we, sb[0].we);
        check("mem_addr", mem_addr, sb[0].addr);
        check("mem_wdata", mem_wdata, sb[0].data);
        void'(sb.pop_front());
      end else begin
        check("no_stray_write", mem_we, '0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic last, input logic valid,
                       input logic exp_wr, input logic [NR-1:0] exp_we,
                       input logic [AW-1:0] exp_addr);
    in_valid = valid;
    in_last  = last;
    in_data  = d;
    if (exp_wr) sb.push_back('{we: exp_we, addr: exp_addr, data: d, due: cyc + 1});
    tick();
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      drive(vt[i].data, vt[i].last, vt[i].valid, vt[i].exp_wr, vt[i].exp_we, vt[i].exp_addr);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_count(input logic [CW-1:0] target, input int budget);
    int n = 0;
    while (cycle_count !== target && n < budget) begin
      tick();
      n++;
    end
    check("cycle_count_reached", cycle_count, target);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic check_run_entry(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_core_rst"}, core_rst, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // valid, last, data, expect write, expected we, expected addr
    vt[0]  = '{1'b1, 1'b0, 32'hA000_0000, 1'b1, 2'b01, 2'd0};
    vt[1]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2'b00, 2'd0};
    vt[2]  = '{1'b1, 1'b0, 32'hA000_0001, 1'b1, 2'b01, 2'd1};
    vt[3]  = '{1'b1, 1'b0, 32'hA000_0002, 1'b1, 2'b01, 2'd2};
    vt[4]  = '{1'b1, 1'b1, 32'hA000_0003, 1'b1, 2'b01, 2'd3};
    vt[5]  = '{1'b1, 1'b0, 32'hD000_0000, 1'b1, 2'b10, 2'd0};
    vt[6]  = '{1'b1, 1'b1, 32'hD000_0001, 1'b1, 2'b10, 2'd1};
    vt[7]  = '{1'b1, 1'b0, 32'hB000_0000, 1'b1, 2'b01, 2'd0};
    vt[8]  = '{1'b1, 1'b0, 32'hB000_0001, 1'b1, 2'b01, 2'd1};
    vt[9]  = '{1'b1, 1'b0, 32'hB000_0002, 1'b1, 2'b01, 2'd2};
    vt[10] = '{1'b1, 1'b0, 32'hB000_0003, 1'b1, 2'b01, 2'd3};
    vt[11] = '{1'b1, 1'b0, 32'hB000_0004, 1'b0, 2'b00, 2'd0};
    vt[12] = '{1'b1, 1'b1, 32'hB000_0005, 1'b0, 2'b00, 2'd0};
    vt[13] = '{1'b1, 1'b1, 32'hC000_0000, 1'b1, 2'b10, 2'd0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; halt = 1'b0;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    check("idle_after_reset_core_rst", core_rst, 1);

    // Two regions with an idle cycle, then halt at count 7
    do_start();
    check("load_in_ready", in_ready, 1);
    check("load_busy", busy, 1);
    apply_range(0, 6);
    check_run_entry("runA");
    wait_count(16'd7, 20);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("haltA_done", done, 1);
    check("haltA_cycle_count", cycle_count, 7);
    check("haltA_timeout", timeout, 0);
    check("haltA_core_rst", core_rst, 1);
    check("haltA_busy", busy, 0);
    tick();
    check("haltA_count_frozen", cycle_count, 7);

    // Overflow of region 0, then run into the timeout
    do_start();
    check("restartB_cycle_count", cycle_count, 0);
    check("restartB_done", done, 0);
    apply_range(7, 13);
    check("ovfB_overflow", overflow, 1);
    check_run_entry("runB");
    for (int n = 0; n < 150 && done !== 1'b1; n++) tick();
    check("toB_done", done, 1);
    check("toB_timeout", timeout, 1);
    check("toB_cycle_count", cycle_count, TO - 1);
    check("toB_overflow_held", overflow, 1);

    // Restart clears flags; start in RUN is ignored; halt coincides with last count
    do_start();
    check("restartC_timeout", timeout, 0);
    check("restartC_overflow", overflow, 0);
    drive(32'hE000_0000, 1'b1, 1'b1, 1'b1, 2'b01, 2'd0);
    drive(32'hE000_0001, 1'b1, 1'b1, 1'b1, 2'b10, 2'd0);
    in_valid = 1'b0; in_last = 1'b0;
    check_run_entry("runC");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("runC_start_ignored_busy", busy, 1);
    check("runC_start_ignored_count", cycle_count, 1);
    wait_count(16'(TO - 1), 150);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("haltC_done", done, 1);
    check("haltC_timeout", timeout, 0);
    check("haltC_cycle_count", cycle_count, TO - 1);

    // Reset on the edge right after a LOAD accept, with another word offered
    do_start();
    drive(32'hF000_0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'd0);
    rst = 1'b1;
    in_data = 32'hF000_0001;
    tick();
    in_valid = 1'b0;
    check_reset("rstload");
    rst = 1'b0;

    // Reset mid-RUN, then a clean rerun
    do_start();
    drive(32'h1000_0000, 1'b1, 1'b1, 1'b1, 2'b01, 2'd0);
    drive(32'h1000_0001, 1'b1, 1'b1, 1'b1, 2'b10, 2'd0);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (5) tick();
    check("rstrun_in_run", core_rst, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rstrun");
    do_start();
    drive(32'h2000_0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'd0);
    drive(32'h2000_0001, 1'b1, 1'b1, 1'b1, 2'b01, 2'd1);
    drive(32'h2000_0002, 1'b1, 1'b1, 1'b1, 2'b10, 2'd0);
    in_valid = 1'b0; in_last = 1'b0;
    check_run_entry("rerun");
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("rerun_done", done, 1);
    check("rerun_cycle_count", cycle_count, 0);

    repeat (2) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
